sme_issue_ctrl: RTL and testbench
=================================

// Module: sme_issue_ctrl
// PURPOSE
//  Issue controller for the SME share datapath. Holds one SME instruction and drives the ALU/crypto valid/ready handshake.
//  Sequences result writeback into the share register files. Arbitrates the single regfile write port and SMECTL updates.
//  Sits between the decode/execute stage and the SME share-state block.
// PARAMETERS
//  MAX_LAT  64  cycles a unit may hold ready low before the watchdog aborts the op.
//  CW       16  width of performance counters (SME_ISSUE_PERF_EN only).
// PORTS
//  g_clk       in   1          global clock; single clock domain.
//  g_reset     in   1          synchronous, active-high reset.
//  g_clk_req   out  1          clock request; high whenever state != IDLE or any request pending.
//  flush       in   1          discard in-flight op.
//  s_valid     in   1          upstream SME instruction valid.
//  s_ready     out  1          controller accepts instruction.
//  s_is_cry    in   1          1=crypto op, 0=ALU op.
//  s_alu_op    in   sme_alu_t  ALU op fields.
//  s_cry_op    in   sme_cry_t  crypto op fields.
//  s_rd_addr   in   4          destination register.
//  alu_valid   out  1          held op to ALU.
//  alu_ready   in   1          ALU completes.
//  alu_op      out  sme_alu_t  registered ALU op.
//  cry_valid   out  1          held op to crypto.
//  cry_ready   in   1          crypto completes.
//  cry_op      out  sme_cry_t  registered crypto op.
//  rf_wen      out  1          result writeback strobe.
//  rf_waddr    out  4          writeback address (held rd).
//  bank_req    in   1          LSU bank load/store request.
//  bank_gnt    out  1          one-cycle grant; LSU drives bank_wen only in this cycle.
//  csr_req     in   1          SMECTL write request.
//  csr_gnt     out  1          one-cycle grant; SMECTL may change only in this cycle.
//  wdog_err    out  1          one-cycle pulse on watchdog abort.
//  perf_ops    out  CW         completed ops.
//  perf_stall  out  CW         cycles s_valid && !s_ready.
// BEHAVIOUR
//  - States: IDLE, ALU_BUSY, CRY_BUSY. Reset -> IDLE; all outputs 0; ops/rd registers 0.
//  - s_ready = !flush && !bank_req && !csr_req && (IDLE || completing).
//    - completing = (ALU_BUSY && alu_ready) || (CRY_BUSY && cry_ready).
//  - Accept (s_valid && s_ready): capture op, rd, kind; next state ALU_BUSY or CRY_BUSY.
//    - alu_valid/cry_valid = registered state decode; first asserted the cycle after accept.
//  - Completion: rf_wen=1, rf_waddr=held rd, same cycle (combinational from ready).
//    - Next state IDLE, or the new busy state if an accept happens the same cycle (back-to-back, zero bubble).
//  - Minimum latency accept->rf_wen: 1 cycle (unit ready in its first valid cycle).
//  - Arbitration, IDLE only: priority csr_req > bank_req > s_valid; grants combinational, one per cycle.
//    - bank_gnt/csr_gnt never asserted while busy or while rf_wen=1, so no regfile write-port collision.
//    - csr_req pending blocks new issue until granted, so SMECTL is stable for every in-flight op.
//  - Flush: any state -> IDLE next cycle; no rf_wen that cycle even if ready=1; no accept that cycle.
//    - unit valid drops next cycle.
//  - Watchdog: counter clears on accept, increments each busy cycle with ready=0.
//    - Reaching MAX_LAT: wdog_err pulse, state -> IDLE, no rf_wen.
//    - Counter width $clog2(MAX_LAT+1); saturates, never wraps.
//  - Reset mid-op: returns to IDLE next edge; no writeback.
// CONFIGURATION
//  SME_ISSUE_PERF_EN defined:
//    - perf_ops += 1 per rf_wen; perf_stall += 1 per stalled cycle.
//    - Both saturate at 2^CW-1; cleared by reset.
//  Undefined: perf_ops/perf_stall tied to 0; no counter flops.
// STRUCTURE
//  sme_pkg additions: sme_issue_state_t enum {IDLE, ALU_BUSY, CRY_BUSY}.
//  The module uses existing sme_alu_t/sme_cry_t.
//  Sub-module sme_issue_perf: saturating counters, instanced only under SME_ISSUE_PERF_EN.
// TESTING
//  1. Reset:
//     - stimulus: reset asserted with s_valid=1, then held 2 cycles.
//     - response: all outputs 0, state IDLE, s_ready=1 after deassert.
//  2. ALU op, rd=5, alu_ready after 3 valid cycles:
//     - alu_valid high 3 cycles.
//     - rf_wen=1, rf_waddr=5 on the 3rd; perf_ops=1.
//  3. Back-to-back:
//     - stimulus: cry op rd=3 completes while ALU op rd=7 offered.
//     - response: rf_wen(3) and accept same cycle; alu_valid the next cycle; no bubble.
//  4. Priority:
//     - stimulus: csr_req, bank_req, s_valid all high in IDLE.
//     - response: csr_gnt cycle 0, bank_gnt cycle 1, accept cycle 2.
//     - response: with op in flight, no grant until after rf_wen.
//  5. Flush:
//     - stimulus: flush asserted in the same cycle as alu_ready=1.
//     - response: rf_wen=0, IDLE next cycle, s_ready=0 that cycle.
//  6. Watchdog:
//     - stimulus: MAX_LAT=4, cry_ready stuck 0.
//     - response: wdog_err on 4th busy cycle; IDLE next; no rf_wen.

Source files
------------

// File: rtl/sme_issue_ctrl_pkg.sv
// ============================================================================
// sme_issue_ctrl_pkg : shared types for the SME issue controller
// Rev 1.0
// ============================================================================
`default_nettype none

package sme_issue_ctrl_pkg;

  typedef struct packed {
    logic [3:0] opc;
    logic [1:0] sel;
  } sme_alu_t;

  typedef struct packed {
    logic [2:0] fn;
    logic [1:0] mode;
  } sme_cry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALU_BUSY = 2'd1,
    CRY_BUSY = 2'd2
  } sme_issue_state_t;

endpackage

`default_nettype wire

// File: rtl/sme_issue_ctrl_if.sv
// ============================================================================
// sme_issue_ctrl_if : upstream, unit, regfile and arbitration signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface sme_issue_ctrl_if
  import sme_issue_ctrl_pkg::*;
#(
  parameter int unsigned CW = 16
);
  logic          g_clk_req;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic          s_is_cry;
  sme_alu_t      s_alu_op;
  sme_cry_t      s_cry_op;
  logic [3:0]    s_rd_addr;
  logic          alu_valid;
  logic          alu_ready;
  sme_alu_t      alu_op;
  logic          cry_valid;
  logic          cry_ready;
  sme_cry_t      cry_op;
  logic          rf_wen;
  logic [3:0]    rf_waddr;
  logic          bank_req;
  logic          bank_gnt;
  logic          csr_req;
  logic          csr_gnt;
  logic          wdog_err;
  logic [CW-1:0] perf_ops;
  logic [CW-1:0] perf_stall;

  modport slave (
    input  flush, s_valid, s_is_cry, s_alu_op, s_cry_op, s_rd_addr,
           alu_ready, cry_ready, bank_req, csr_req,
    output g_clk_req, s_ready, alu_valid, alu_op, cry_valid, cry_op,
           rf_wen, rf_waddr, bank_gnt, csr_gnt, wdog_err, perf_ops, perf_stall
  );

  modport master (
    output flush, s_valid, s_is_cry, s_alu_op, s_cry_op, s_rd_addr,
           alu_ready, cry_ready, bank_req, csr_req,
    input  g_clk_req, s_ready, alu_valid, alu_op, cry_valid, cry_op,
           rf_wen, rf_waddr, bank_gnt, csr_gnt, wdog_err, perf_ops, perf_stall
  );

endinterface

`default_nettype wire

// File: rtl/sme_issue_ctrl_perf.sv
// ============================================================================
// sme_issue_perf : saturating completed-op and stall-cycle counters
// Rev 1.0
// ============================================================================
`default_nettype none

module sme_issue_perf #(
  parameter int unsigned CW = 16
) (
  input  wire logic          g_clk,
  input  wire logic          g_reset,
  input  wire logic          ops_inc,
  input  wire logic          stall_inc,
  output logic [CW-1:0]      perf_ops,
  output logic [CW-1:0]      perf_stall
);

  logic [CW-1:0] ops_q, ops_d;
  logic [CW-1:0] stall_q, stall_d;

  always_comb begin
    ops_d   = ops_q;
    stall_d = stall_q;
    if (ops_inc && (ops_q != {CW{1'b1}}))
      ops_d = ops_q + CW'(1);
    if (stall_inc && (stall_q != {CW{1'b1}}))
      stall_d = stall_q + CW'(1);
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      ops_q   <= ops_d;
      stall_q <= stall_d;
    end
  end

  assign perf_ops   = ops_q;
  assign perf_stall = stall_q;

endmodule

`default_nettype wire

// File: rtl/sme_issue_ctrl.sv
// ============================================================================
// sme_issue_ctrl : single-op SME issue controller with regfile/SMECTL arbitration
// Optional build macro: SME_ISSUE_PERF_EN (perf counters).   Rev 1.0
// ============================================================================
`default_nettype none

module sme_issue_ctrl
  import sme_issue_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LAT = 64,
  parameter int unsigned CW      = 16
) (
  input  wire logic        g_clk,
  input  wire logic        g_reset,
  sme_issue_ctrl_if.slave  bus
);

  localparam int unsigned     c_wd_w    = $clog2(MAX_LAT + 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(MAX_LAT - 1);
  localparam logic [c_wd_w-1:0] c_wd_max  = c_wd_w'(MAX_LAT);

  sme_issue_state_t    state_q, state_d;
  sme_alu_t            alu_op_q, alu_op_d;
  sme_cry_t            cry_op_q, cry_op_d;
  logic [3:0]          rd_q, rd_d;
  logic [c_wd_w-1:0]   wdog_q, wdog_d;

  logic busy, completing, ready_ok, accept, wdog_hit;

  // Shared decode used by both next-state and output processes
  always_comb begin
    busy       = (state_q != IDLE);
    completing = ((state_q == ALU_BUSY) && bus.alu_ready) ||
                 ((state_q == CRY_BUSY) && bus.cry_ready);
    ready_ok   = !g_reset && !bus.flush && !bus.bank_req && !bus.csr_req &&
                 (!busy || completing);
    accept     = bus.s_valid && ready_ok;
    wdog_hit   = !g_reset && !bus.flush && busy && !completing && (wdog_q == c_wd_last);
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q  <= IDLE;
      alu_op_q <= '0;
      cry_op_q <= '0;
      rd_q     <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      cry_op_q <= cry_op_d;
      rd_q     <= rd_d;
      wdog_q   <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush)
      state_d = IDLE;
    else if (accept)
      state_d = bus.s_is_cry ? CRY_BUSY : ALU_BUSY;
    else if (completing || wdog_hit)
      state_d = IDLE;
  end

  // Op capture and watchdog; the counter saturates so an abort never re-arms by wrapping
  always_comb begin
    alu_op_d = alu_op_q;
    cry_op_d = cry_op_q;
    rd_d     = rd_q;
    wdog_d   = wdog_q;
    if (accept) begin
      rd_d   = bus.s_rd_addr;
      wdog_d = '0;
      if (bus.s_is_cry)
        cry_op_d = bus.s_cry_op;
      else
        alu_op_d = bus.s_alu_op;
    end else if (busy && !completing && (wdog_q != c_wd_max)) begin
      wdog_d = wdog_q + c_wd_w'(1);
    end
  end

  always_comb begin
    bus.s_ready   = ready_ok;
    bus.alu_valid = !g_reset && (state_q == ALU_BUSY);
    bus.cry_valid = !g_reset && (state_q == CRY_BUSY);
    bus.alu_op    = alu_op_q;
    bus.cry_op    = cry_op_q;
    bus.rf_wen    = !g_reset && !bus.flush && completing;
    bus.rf_waddr  = rd_q;
    bus.csr_gnt   = !g_reset && !busy && bus.csr_req;
    bus.bank_gnt  = !g_reset && !busy && bus.bank_req && !bus.csr_req;
    bus.wdog_err  = wdog_hit;
    bus.g_clk_req = !g_reset && (busy || bus.s_valid || bus.bank_req || bus.csr_req);
  end

`ifdef SME_ISSUE_PERF_EN
  sme_issue_perf #(.CW(CW)) u_perf (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .ops_inc    (bus.rf_wen),
    .stall_inc  (bus.s_valid && !ready_ok),
    .perf_ops   (bus.perf_ops),
    .perf_stall (bus.perf_stall)
  );
`else
  assign bus.perf_ops   = {CW{1'b0}};
  assign bus.perf_stall = {CW{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_sme_issue_ctrl.sv
// ============================================================================
// tb_sme_issue_ctrl : directed self-checking bench for sme_issue_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sme_issue_ctrl;
  import sme_issue_ctrl_pkg::*;

`ifdef SME_ISSUE_PERF_EN
  localparam bit c_perf = 1'b1;
`else
  localparam bit c_perf = 1'b0;
`endif

  logic g_clk = 1'b0;
  logic g_reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 g_clk = ~g_clk;

  sme_issue_ctrl_if #(.CW(16)) bus ();

  sme_issue_ctrl #(.MAX_LAT(4), .CW(16)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus)
  );

  task automatic next_cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge g_clk);
  endtask

  task automatic test_reset();
    logic [33:0] outs;
    g_reset = 1'b1;
    bus.s_valid = 1'b1; bus.s_is_cry = 1'b0;
    bus.s_alu_op = sme_alu_t'(6'h2A); bus.s_rd_addr = 4'd9;
    next_cyc(); next_cyc();
    at_neg();
    outs = {bus.g_clk_req, bus.s_ready, bus.alu_valid, bus.cry_valid, bus.rf_wen,
            bus.bank_gnt, bus.csr_gnt, bus.wdog_err, bus.rf_waddr, bus.alu_op,
            bus.cry_op, bus.perf_ops[5:0], bus.perf_stall[3:0]};
    n_cmp++; if (outs !== 34'h0) begin n_err++; $display("FAIL reset_outs got=%h exp=0", outs); end
    g_reset = 1'b0; bus.s_valid = 1'b0;
    #1;
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got=%0b exp=1", bus.s_ready); end
    next_cyc();
  endtask

  task automatic test_alu();
    logic [15:0] exp_ops;
    bus.s_valid = 1'b1; bus.s_is_cry = 1'b0;
    bus.s_alu_op = sme_alu_t'(6'h1D); bus.s_rd_addr = 4'd5;
    at_neg();
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL alu_accept got=%0b exp=1", bus.s_ready); end
    next_cyc(); bus.s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.alu_ready = 1'b1;
      at_neg();
      n_cmp++; if (bus.alu_valid !== 1'b1) begin n_err++; $display("FAIL alu_valid_c%0d got=%0b exp=1", i, bus.alu_valid); end
      n_cmp++; if (bus.rf_wen !== (i == 2)) begin n_err++; $display("FAIL alu_rf_wen_c%0d got=%0b exp=%0b", i, bus.rf_wen, i == 2); end
      next_cyc();
    end
    bus.alu_ready = 1'b0;
    at_neg();
    n_cmp++; if (bus.rf_waddr !== 4'd5) begin n_err++; $display("FAIL alu_waddr got=%0d exp=5", bus.rf_waddr); end
    n_cmp++; if (bus.alu_op !== sme_alu_t'(6'h1D)) begin n_err++; $display("FAIL alu_op got=%h exp=1d", bus.alu_op); end
    n_cmp++; if (bus.alu_valid !== 1'b0) begin n_err++; $display("FAIL alu_valid_drop got=%0b exp=0", bus.alu_valid); end
    exp_ops = c_perf ? 16'd1 : 16'd0;
    n_cmp++; if (bus.perf_ops !== exp_ops) begin n_err++; $display("FAIL alu_perf_ops got=%0d exp=%0d", bus.perf_ops, exp_ops); end
    next_cyc();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_ops;
    bus.s_valid = 1'b1; bus.s_is_cry = 1'b1;
    bus.s_cry_op = sme_cry_t'(5'h13); bus.s_rd_addr = 4'd3;
    next_cyc();
    bus.s_is_cry = 1'b0; bus.s_alu_op = sme_alu_t'(6'h07); bus.s_rd_addr = 4'd7;
    bus.cry_ready = 1'b1;
    at_neg();
    n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 4'd3) begin n_err++; $display("FAIL b2b_wb got=%0b/%0d exp=1/3", bus.rf_wen, bus.rf_waddr); end
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL b2b_accept got=%0b exp=1", bus.s_ready); end
    n_cmp++; if (bus.cry_op !== sme_cry_t'(5'h13)) begin n_err++; $display("FAIL b2b_cry_op got=%h exp=13", bus.cry_op); end
    next_cyc();
    bus.s_valid = 1'b0; bus.cry_ready = 1'b0; bus.alu_ready = 1'b1;
    at_neg();
    n_cmp++; if ({bus.alu_valid, bus.cry_valid} !== 2'b10) begin n_err++; $display("FAIL b2b_valids got=%b exp=10", {bus.alu_valid, bus.cry_valid}); end
    n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 4'd7) begin n_err++; $display("FAIL b2b_wb2 got=%0b/%0d exp=1/7", bus.rf_wen, bus.rf_waddr); end
    next_cyc();
    bus.alu_ready = 1'b0;
    at_neg();
    exp_ops = c_perf ? 16'd3 : 16'd0;
    n_cmp++; if (bus.perf_ops !== exp_ops) begin n_err++; $display("FAIL b2b_perf_ops got=%0d exp=%0d", bus.perf_ops, exp_ops); end
    next_cyc();
  endtask

  task automatic test_priority();
    logic [15:0] exp_st;
    bus.csr_req = 1'b1; bus.bank_req = 1'b1; bus.s_valid = 1'b1;
    bus.s_is_cry = 1'b0; bus.s_rd_addr = 4'd9;
    at_neg();
    n_cmp++; if ({bus.csr_gnt, bus.bank_gnt, bus.s_ready} !== 3'b100) begin n_err++; $display("FAIL prio_c0 got=%b exp=100", {bus.csr_gnt, bus.bank_gnt, bus.s_ready}); end
    next_cyc(); bus.csr_req = 1'b0;
    at_neg();
    n_cmp++; if ({bus.csr_gnt, bus.bank_gnt, bus.s_ready} !== 3'b010) begin n_err++; $display("FAIL prio_c1 got=%b exp=010", {bus.csr_gnt, bus.bank_gnt, bus.s_ready}); end
    next_cyc(); bus.bank_req = 1'b0;
    at_neg();
    n_cmp++; if ({bus.csr_gnt, bus.bank_gnt, bus.s_ready} !== 3'b001) begin n_err++; $display("FAIL prio_c2 got=%b exp=001", {bus.csr_gnt, bus.bank_gnt, bus.s_ready}); end
    exp_st = c_perf ? 16'd2 : 16'd0;
    n_cmp++; if (bus.perf_stall !== exp_st) begin n_err++; $display("FAIL prio_perf_stall got=%0d exp=%0d", bus.perf_stall, exp_st); end
    next_cyc(); bus.s_valid = 1'b0; bus.csr_req = 1'b1;
    at_neg();
    n_cmp++; if (bus.csr_gnt !== 1'b0 || bus.alu_valid !== 1'b1) begin n_err++; $display("FAIL prio_busy_gnt got=%0b/%0b exp=0/1", bus.csr_gnt, bus.alu_valid); end
    next_cyc(); bus.alu_ready = 1'b1;
    at_neg();
    n_cmp++; if ({bus.rf_wen, bus.csr_gnt, bus.s_ready} !== 3'b100) begin n_err++; $display("FAIL prio_wb_gnt got=%b exp=100", {bus.rf_wen, bus.csr_gnt, bus.s_ready}); end
    next_cyc(); bus.alu_ready = 1'b0;
    at_neg();
    n_cmp++; if (bus.csr_gnt !== 1'b1) begin n_err++; $display("FAIL prio_late_gnt got=%0b exp=1", bus.csr_gnt); end
    next_cyc(); bus.csr_req = 1'b0;
  endtask

  task automatic test_flush();
    logic [15:0] exp_st;
    bus.s_valid = 1'b1; bus.s_is_cry = 1'b0; bus.s_rd_addr = 4'd2;
    next_cyc(); bus.s_valid = 1'b0;
    next_cyc();
    bus.alu_ready = 1'b1; bus.flush = 1'b1; bus.s_valid = 1'b1;
    at_neg();
    n_cmp++; if ({bus.rf_wen, bus.s_ready} !== 2'b00) begin n_err++; $display("FAIL flush_wb got=%b exp=00", {bus.rf_wen, bus.s_ready}); end
    next_cyc();
    bus.alu_ready = 1'b0; bus.flush = 1'b0; bus.s_valid = 1'b0;
    at_neg();
    n_cmp++; if ({bus.alu_valid, bus.g_clk_req} !== 2'b00) begin n_err++; $display("FAIL flush_idle got=%b exp=00", {bus.alu_valid, bus.g_clk_req}); end
    exp_st = c_perf ? 16'd3 : 16'd0;
    n_cmp++; if (bus.perf_stall !== exp_st) begin n_err++; $display("FAIL flush_perf_stall got=%0d exp=%0d", bus.perf_stall, exp_st); end
    next_cyc();
  endtask

  task automatic test_watchdog();
    bus.s_valid = 1'b1; bus.s_is_cry = 1'b1; bus.s_rd_addr = 4'd4;
    next_cyc(); bus.s_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      at_neg();
      n_cmp++; if (bus.wdog_err !== (i == 4)) begin n_err++; $display("FAIL wdog_c%0d got=%0b exp=%0b", i, bus.wdog_err, i == 4); end
      n_cmp++; if (bus.rf_wen !== 1'b0 || bus.cry_valid !== 1'b1) begin n_err++; $display("FAIL wdog_busy_c%0d got=%0b/%0b exp=0/1", i, bus.rf_wen, bus.cry_valid); end
      next_cyc();
    end
    at_neg();
    n_cmp++; if ({bus.cry_valid, bus.wdog_err, bus.s_ready} !== 3'b001) begin n_err++; $display("FAIL wdog_idle got=%b exp=001", {bus.cry_valid, bus.wdog_err, bus.s_ready}); end
    next_cyc();
  endtask

  task automatic test_reset_mid_op();
    bus.s_valid = 1'b1; bus.s_is_cry = 1'b0; bus.s_rd_addr = 4'd6;
    next_cyc(); bus.s_valid = 1'b0; g_reset = 1'b1; bus.alu_ready = 1'b1;
    next_cyc(); g_reset = 1'b0;
    at_neg();
    n_cmp++; if ({bus.alu_valid, bus.rf_wen, bus.rf_waddr} !== 6'h0) begin n_err++; $display("FAIL rst_mid got=%b exp=0", {bus.alu_valid, bus.rf_wen, bus.rf_waddr}); end
    next_cyc(); bus.alu_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    g_reset = 1'b0;
    bus.flush = 1'b0; bus.s_valid = 1'b0; bus.s_is_cry = 1'b0;
    bus.s_alu_op = '0; bus.s_cry_op = '0; bus.s_rd_addr = '0;
    bus.alu_ready = 1'b0; bus.cry_ready = 1'b0;
    bus.bank_req = 1'b0; bus.csr_req = 1'b0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_priority();
    test_flush();
    test_watchdog();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
